// File: rtl/pipe_pkg.sv
// Shared definitions for the memory pipeline stage: mem_op encodings, FSM states
// and small op-class helpers.
package pipe_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables and replication, load lane
// selection with sign/zero extension, and the alignment check.
module mem_align
    import pipe_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (addr)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be       = 4'b0000;
        wdata    = st_data;
        ldata    = 32'd0;
        misalign = 1'b0;
        case (op)
            OP_LB: begin
                be    = 4'b1111;
                ldata = {{24{lane_b[7]}}, lane_b};
            end
            OP_LBU: begin
                be    = 4'b1111;
                ldata = {24'd0, lane_b};
            end
            OP_LH: begin
                be       = 4'b1111;
                ldata    = {{16{lane_h[15]}}, lane_h};
                misalign = addr[0];
            end
            OP_LHU: begin
                be       = 4'b1111;
                ldata    = {16'd0, lane_h};
                misalign = addr[0];
            end
            OP_LW: begin
                be       = 4'b1111;
                ldata    = rdata;
                misalign = |addr;
            end
            OP_SB: begin
                be    = 4'b0001 << addr;
                wdata = {4{st_data[7:0]}};
            end
            OP_SH: begin
                be       = 4'b0011 << addr;
                wdata    = {2{st_data[15:0]}};
                misalign = addr[0];
            end
            OP_SW: begin
                be       = 4'b1111;
                misalign = |addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_mem.sv
// MEM pipeline stage: 4-phase handshakes toward EX and WB, a single data-memory
// request per load/store, and lane alignment through mem_align.
module pipe_mem #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_syn,
    output logic          up_ack,
    output logic          down_syn,
    input  logic          down_ack,
    input  logic [3:0]    mem_op,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] st_data,
    input  logic          wb_e,
    input  logic [4:0]    idxin,
    output logic [DW-1:0] dout,
    output logic [4:0]    idxout,
    output logic          wb_e_out,
    output logic          dm_req,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata,
    input  logic          dm_ack,
    output logic          misalign
);
    import pipe_pkg::*;

    state_e      state_q, state_d;
    logic        capture;
    logic        is_mem;
    logic [3:0]  op_q;
    logic [1:0]  lsb_q;
    logic [3:0]  align_op;
    logic [1:0]  align_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic        al_misalign;

    // In IDLE the aligner sees the live EX inputs; afterwards the captured op/addr.
    assign capture    = (state_q == IDLE) && up_syn && !up_ack;
    assign is_mem     = is_load(mem_op) || is_store(mem_op);
    assign align_op   = (state_q == IDLE) ? mem_op : op_q;
    assign align_addr = (state_q == IDLE) ? addr_in[1:0] : lsb_q;

    mem_align u_align (
        .op       (align_op),
        .addr     (align_addr),
        .rdata    (dm_rdata),
        .st_data  (st_data),
        .be       (al_be),
        .wdata    (al_wdata),
        .ldata    (al_ldata),
        .misalign (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = (is_mem && !al_misalign) ? ACCESS : SEND;
                end
            end
            ACCESS:  if (dm_ack)    state_d = SEND;
            SEND:    if (down_ack)  state_d = RELEASE;
            RELEASE: if (!down_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered so the WB side sees them stable for the whole SEND phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_ack   <= 1'b0;
            down_syn <= 1'b0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= 4'b0000;
            dm_wdata <= '0;
            dout     <= '0;
            idxout   <= 5'd0;
            wb_e_out <= 1'b0;
            misalign <= 1'b0;
            op_q     <= 4'd0;
            lsb_q    <= 2'd0;
        end else begin
            misalign <= 1'b0;
            if (up_ack && !up_syn) begin
                up_ack <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        up_ack <= 1'b1;
                        op_q   <= mem_op;
                        lsb_q  <= addr_in[1:0];
                        idxout <= idxin;
                        dout   <= DW'(addr_in);
                        if (is_mem && al_misalign) begin
                            misalign <= 1'b1;
                            wb_e_out <= 1'b0;
                            down_syn <= 1'b1;
                        end else if (is_mem) begin
                            dm_req   <= 1'b1;
                            dm_we    <= is_store(mem_op);
                            dm_addr  <= {addr_in[AW-1:2], 2'b00};
                            dm_be    <= al_be;
                            dm_wdata <= al_wdata;
                            wb_e_out <= is_store(mem_op) ? 1'b0 : wb_e;
                        end else begin
                            wb_e_out <= wb_e;
                            down_syn <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        dm_req   <= 1'b0;
                        dm_we    <= 1'b0;
                        down_syn <= 1'b1;
                        if (is_load(op_q)) begin
                            dout <= al_ldata;
                        end
                    end
                end
                SEND: begin
                    if (down_ack) begin
                        down_syn <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pipe_mem.md
PIPE_MEM -- requirements
Module: pipe_mem

Interface
REQ-001 SHALL have parameter AW, default 32, meaning data-memory byte-address width.
REQ-002 SHALL have parameter DW, default 32, meaning data word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have ports up_syn input 1 and up_ack output 1, the 4-phase handshake from the EX stage.
REQ-006 SHALL have ports down_syn output 1 and down_ack input 1, the 4-phase handshake to the WB stage.
REQ-007 SHALL have port mem_op, input, 4: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, others treated as none.
REQ-008 SHALL have ports addr_in input AW (ALU result or effective address), st_data input 32, wb_e input 1, and idxin input 5.
REQ-009 SHALL have ports dout output 32, idxout output 5, and wb_e_out output 1; these feed the WB stage's din, idxin and wb_e.
REQ-010 SHALL have ports dm_req output 1, dm_we output 1, dm_addr output AW, dm_be output 4, dm_wdata output 32, dm_rdata input 32, and dm_ack input 1.
REQ-011 SHALL have port misalign, output 1, a one-cycle pulse on a misaligned access.

Function
REQ-012 SHALL use FSM states IDLE, ACCESS, SEND, and RELEASE.
REQ-013 IDLE: when up_syn=1 and up_ack=0, SHALL capture all EX inputs into registers, set up_ack=1 next cycle, and go to ACCESS if mem_op is a load/store, else SEND.
REQ-014 SHALL hold up_ack=1 until up_syn is sampled 0, then clear it next cycle; capture of the next item SHALL NOT occur while up_ack=1.
REQ-015 Alignment rule: halfword ops need addr[0]=0 and word ops need addr[1:0]=0; a violation SHALL skip ACCESS, pulse misalign, force wb_e_out=0, and go to SEND.
REQ-016 ACCESS SHALL drive dm_req=1, dm_addr={addr[AW-1:2],2'b00}, and dm_we=1 for stores, holding all dm_* outputs stable until dm_ack=1 is sampled.
REQ-017 dm_req SHALL drop in the cycle after dm_ack is sampled; dm_ack SHALL be ignored outside ACCESS.
REQ-018 Store byte enables (little-endian) SHALL be: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<addr[1:0]; SW gives 4'b1111. Loads SHALL drive dm_be=4'b1111.
REQ-019 Store data SHALL be replicated: SB byte to all 4 lanes, SH half to both halves, SW unchanged.
REQ-020 Loads SHALL select the lane by addr[1:0] and sign-extend (LB, LH) or zero-extend (LBU, LHU); LW passes dm_rdata through.
REQ-021 dout SHALL be: the load result for loads; addr_in for mem_op=none; addr_in for stores, with wb_e_out=0 for stores.
REQ-022 SEND SHALL drive down_syn=1 with dout, idxout and wb_e_out stable, until down_ack is sampled 1, then go to RELEASE with down_syn=0.
REQ-023 RELEASE SHALL wait for down_ack=0, then go to IDLE.
REQ-024 Minimum latency, non-memory op: up_syn sampled in cycle N gives down_syn=1 in cycle N+1. Memory op with dm_ack=1 in the first ACCESS cycle gives down_syn=1 in cycle N+2.
REQ-025 If up_syn rises while in ACCESS, SEND, or RELEASE, SHALL leave the new item unacknowledged until IDLE; no item may be dropped or duplicated.

Reset
REQ-026 rst=1 sampled at a clock edge SHALL force IDLE and clear every output to 0 (up_ack, down_syn, dm_req, dm_we, dm_addr, dm_be, dm_wdata, dout, idxout, wb_e_out, misalign).
REQ-027 Reset in mid-ACCESS SHALL abandon the transaction, dropping dm_req next cycle; a late dm_ack SHALL be ignored.

Structure
REQ-028 Shared package pipe_pkg SHALL hold the mem_op encodings and the FSM state encoding.
REQ-029 Lane select and extension SHALL live in a combinational sub-module mem_align (inputs op, addr[1:0], rdata, st_data; outputs be, wdata, ldata, misalign).

Verification
REQ-030 Check LB of addr 0x103 with dm_rdata=0x80FF_1234 -> dm_addr=0x100, dout=0xFFFF_FF80, idxout=idxin, wb_e_out=1.
REQ-031 Check SH of addr 0x202 with st_data=0x0000_ABCD -> dm_we=1, dm_be=4'b1100, dm_wdata=0xABCD_ABCD, wb_e_out=0.
REQ-032 Check LW of addr 0x006 -> no dm_req, misalign pulses 1 cycle, wb_e_out=0, down_syn=1 next cycle.
REQ-033 Check mem_op=none, addr_in=42, idxin=5, wb_e=1 -> dout=42, idxout=5, wb_e_out=1, down_syn at N+1.
REQ-034 Check dm_ack delayed 5 cycles with down_ack held low 3 cycles -> outputs stay stable, exactly one up_ack/down_syn cycle per item.
REQ-035 Check rst asserted mid-ACCESS, then dm_ack=1 -> all outputs 0 next cycle, state IDLE, late ack ignored.
